tmds_channel_decoder: RTL and testbench

Receive-side counterpart of the HDMI TMDS channel encoder. Takes raw, unaligned 10-bit parallel words from a 1:10 deserializer on the pixel clock. It finds the symbol boundary by locking onto control tokens, then recovers per-pixel 8-bit data, the 2-bit control value and data-enable. One instance per TMDS data channel, feeding a downstream sync/timing checker.

---
 rtl/tmds_channel_decoder.sv | 146 ++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - TMDS channel receiver: token-based word alignment and 10b->8b decode
module tmds_channel_decoder #(
  parameter int TOKEN_RUN      = 16,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [9:0] i_raw,
  output logic [7:0] o_data,
  output logic [1:0] o_ctrl,
  output logic       o_de,
  output logic       o_locked,
  output logic [3:0] o_offset
);

  localparam logic [12:0] RUN_LAST    = 13'(TOKEN_RUN - 1);
  localparam logic [12:0] SEARCH_LAST = 13'(SEARCH_TIMEOUT - 1);
  localparam logic [12:0] LOSS_LAST   = 13'(LOSS_TIMEOUT - 1);

  typedef enum logic [0:0] {SEARCH, LOCKED} state_t;

  state_t      state, state_n;
  logic [3:0]  offset, offset_n;
  logic [12:0] run_cnt, run_n, idle_cnt, idle_n;
  logic [9:0]  prev_raw;
  logic [7:0]  data_n;
  logic [1:0]  ctrl_n;
  logic        de_n;

  logic [19:0] hist;
  logic [9:0]  w;
  logic        is_token;
  logic [1:0]  tok_ctrl;
  logic [7:0]  t;
  logic [7:0]  d;
  logic [12:0] run_inc, idle_inc;

  // Bit 0 of each word arrives first, so the older word occupies the low half.
  assign hist = {i_raw, prev_raw};
  assign w    = hist[offset +: 10];

  always_comb begin
    is_token = 1'b1;
    tok_ctrl = 2'b00;
    case (w)
      10'b1101010100: tok_ctrl = 2'b00;
      10'b0010101011: tok_ctrl = 2'b01;
      10'b0101010100: tok_ctrl = 2'b10;
      10'b1010101011: tok_ctrl = 2'b11;
      default:        is_token = 1'b0;
    endcase
  end

  assign t = w[9] ? ~w[7:0] : w[7:0];

  always_comb begin
    d    = 8'h00;
    d[0] = t[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = w[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    end
  end

  assign run_inc  = (run_cnt == 13'h1FFF) ? run_cnt : run_cnt + 13'd1;
  assign idle_inc = (idle_cnt == 13'h1FFF) ? idle_cnt : idle_cnt + 13'd1;

  always_comb begin
    state_n  = state;
    offset_n = offset;
    run_n    = run_cnt;
    idle_n   = idle_cnt;
    data_n   = o_data;
    ctrl_n   = o_ctrl;
    de_n     = o_de;
    case (state)
      SEARCH: begin
        data_n = 8'h00;
        ctrl_n = 2'b00;
        de_n   = 1'b0;
        // Lock has priority over a coincident search timeout.
        if (is_token && run_cnt == RUN_LAST) begin
          state_n = LOCKED;
          run_n   = 13'd0;
          idle_n  = 13'd0;
        end else if (idle_cnt == SEARCH_LAST) begin
          offset_n = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
          run_n    = 13'd0;
          idle_n   = 13'd0;
        end else if (is_token) begin
          run_n  = run_inc;
          idle_n = 13'd0;
        end else begin
          run_n  = 13'd0;
          idle_n = idle_inc;
        end
      end
      LOCKED: begin
        if (is_token) begin
          ctrl_n = tok_ctrl;
          de_n   = 1'b0;
          data_n = 8'h00;
          idle_n = 13'd0;
        end else if (idle_cnt == LOSS_LAST) begin
          state_n = SEARCH;
          run_n   = 13'd0;
          idle_n  = 13'd0;
          de_n    = 1'b0;
          data_n  = 8'h00;
          ctrl_n  = 2'b00;
        end else begin
          data_n = d;
          de_n   = 1'b1;
          idle_n = idle_inc;
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= SEARCH;
      offset   <= 4'd0;
      run_cnt  <= 13'd0;
      idle_cnt <= 13'd0;
      prev_raw <= 10'd0;
      o_data   <= 8'h00;
      o_ctrl   <= 2'b00;
      o_de     <= 1'b0;
    end else begin
      state    <= state_n;
      offset   <= offset_n;
      run_cnt  <= run_n;
      idle_cnt <= idle_n;
      prev_raw <= i_raw;
      o_data   <= data_n;
      o_ctrl   <= ctrl_n;
      o_de     <= de_n;
    end
  end

  assign o_locked = (state == LOCKED);
  assign o_offset = offset;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb/tb_tmds_channel_decoder.sv - scoreboard bench for tmds_channel_decoder
module tb_tmds_channel_decoder;

  localparam logic [9:0] TK00 = 10'b1101010100;
  localparam logic [9:0] TK01 = 10'b0010101011;
  localparam logic [9:0] TK11 = 10'b1010101011;

  logic       clk = 1'b0;
  logic       resetn, resetn2;
  logic [9:0] i_raw, raw2;
  logic [7:0] o_data, data2;
  logic [1:0] o_ctrl, ctrl2;
  logic       o_de, de2, o_locked, locked2;
  logic [3:0] o_offset, offset2;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  tmds_channel_decoder #(.TOKEN_RUN(4), .SEARCH_TIMEOUT(64), .LOSS_TIMEOUT(64)) u_dut (
    .clk(clk), .resetn(resetn), .i_raw(i_raw), .o_data(o_data), .o_ctrl(o_ctrl),
    .o_de(o_de), .o_locked(o_locked), .o_offset(o_offset)
  );

  // Single-token lock lets the lock/timeout tie actually occur.
  tmds_channel_decoder #(.TOKEN_RUN(1), .SEARCH_TIMEOUT(8), .LOSS_TIMEOUT(8)) u_tie (
    .clk(clk), .resetn(resetn2), .i_raw(raw2), .o_data(data2), .o_ctrl(ctrl2),
    .o_de(de2), .o_locked(locked2), .o_offset(offset2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic [9:0] r);
    i_raw = r;
    @(posedge clk);
    #1;
  endtask

  task automatic tick2(input logic [9:0] r);
    raw2 = r;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    logic [7:0] e;
    if (resetn === 1'b1) begin
      checks++;
      if (o_de === 1'b1 && o_locked !== 1'b1) begin
        failures++;
        $display("FAIL de_without_lock actual_de=%b actual_locked=%b", o_de, o_locked);
      end
    end
    if (o_de === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_de actual=%0h required=no_word", o_data);
      end else begin
        e = exp_q.pop_front();
        check("data_word", 32'(o_data), 32'(e));
      end
    end
  end

  initial begin : stim
    logic [9:0] r3;
    logic [3:0] last_off;
    int lock_tick;
    int chg[$];
    r3 = {TK00[6:0], TK00[9:7]};
    resetn = 1'b0; resetn2 = 1'b0; i_raw = 10'd0; raw2 = 10'd0;

    repeat (2) begin
      tick(10'($urandom));
      check("rst_data", 32'(o_data), 0);
      check("rst_ctrl", 32'(o_ctrl), 0);
      check("rst_de", 32'(o_de), 0);
      check("rst_locked", 32'(o_locked), 0);
      check("rst_offset", 32'(o_offset), 0);
    end

    // Token stream aligned at offset 3.
    resetn = 1'b1;
    lock_tick = 0;
    last_off = o_offset;
    for (int n = 1; n <= 400 && lock_tick == 0; n++) begin
      tick(r3);
      if (o_offset !== last_off) begin
        chg.push_back(n);
        last_off = o_offset;
      end
      if (o_locked === 1'b1) lock_tick = n;
    end
    check("slip_count", 32'(chg.size()), 3);
    for (int i = 0; i < 3 && i < chg.size(); i++) check("slip_tick", 32'(chg[i]), 32'(64 * (i + 1)));
    check("lock_tick", 32'(lock_tick), 196);
    check("lock_offset", 32'(o_offset), 3);

    resetn = 1'b0;
    tick(r3);
    check("midlock_rst_locked", 32'(o_locked), 0);
    check("midlock_rst_offset", 32'(o_offset), 0);
    check("midlock_rst_de", 32'(o_de), 0);

    resetn = 1'b1;
    repeat (4) tick(TK00);
    check("lock0_early", 32'(o_locked), 0);
    tick(TK00);
    check("lock0", 32'(o_locked), 1);
    check("lock0_offset", 32'(o_offset), 0);
    tick(TK00);
    check("lock0_ctrl", 32'(o_ctrl), 0);

    exp_q.push_back(8'h00);
    tick(10'h100);
    exp_q.push_back(8'hFE);
    tick(10'h2FF);
    check("dec100_de", 32'(o_de), 1);
    check("dec100_data", 32'(o_data), 32'h00);
    tick(TK01);
    check("dec2ff_de", 32'(o_de), 1);
    check("dec2ff_data", 32'(o_data), 32'hFE);
    tick(TK11);
    check("tok01_ctrl", 32'(o_ctrl), 1);
    check("tok01_de", 32'(o_de), 0);
    check("tok01_data", 32'(o_data), 0);
    exp_q.push_back(8'h10);
    tick(10'h1F0);
    check("tok11_ctrl", 32'(o_ctrl), 3);
    check("tok11_de", 32'(o_de), 0);
    tick(TK00);
    check("hold_de", 32'(o_de), 1);
    check("hold_ctrl", 32'(o_ctrl), 3);
    check("hold_data", 32'(o_data), 32'h10);
    tick(TK00);
    check("tok00_ctrl", 32'(o_ctrl), 0);

    // Loss of lock: 64 data words, the last of which trips the timeout.
    for (int k = 1; k <= 64; k++) begin
      if (k <= 63) exp_q.push_back((k % 2 == 1) ? 8'h00 : 8'hFE);
      tick((k % 2 == 1) ? 10'h100 : 10'h2FF);
    end
    check("loss_before", 32'(o_locked), 1);
    tick(10'h000);
    check("loss_locked", 32'(o_locked), 0);
    check("loss_de", 32'(o_de), 0);
    check("loss_offset", 32'(o_offset), 0);

    for (int t = 1; t <= 640; t++) begin
      tick(10'h000);
      if (t % 64 == 63) check("pre_slip_offset", 32'(o_offset), 32'((t / 64) % 10));
      if (t % 64 == 0) check("wrap_offset", 32'(o_offset), 32'((t / 64) % 10));
    end
    check("wrap_unlocked", 32'(o_locked), 0);

    resetn2 = 1'b1;
    repeat (6) tick2(10'h000);
    tick2(TK00);
    check("tie_pre_locked", 32'(locked2), 0);
    tick2(10'h000);
    check("tie_locked", 32'(locked2), 1);
    check("tie_offset", 32'(offset2), 0);

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
